// File: rtl/robot_pkg.sv
// Shared types and bit positions for the robot direction path.
// Used by direction_cmd_buffer and its FIFO.
package robot_pkg;

  typedef enum logic [1:0] {
    DIR_STRAIGHT = 2'b00,
    DIR_LEFT     = 2'b01,
    DIR_RIGHT    = 2'b10,
    DIR_UTURN    = 2'b11
  } dir_code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } cmd_state_t;

  localparam int UPD_BIT = 2;
  localparam int DIR_MSB = 1;

endpackage

// File: rtl/dir_fifo.sv
// Circular synchronous FIFO for direction codes; a push into a full FIFO is
// dropped unless a pop frees a slot in the same cycle.
module dir_fifo
  import robot_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/direction_cmd_buffer.sv
// Detects update-bit toggles on the decoder output, queues direction codes and
// issues them one at a time to the motion controller. Watchdog: DIR_BUFFER_TIMEOUT_EN.
module direction_cmd_buffer
  import robot_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             dir_in,
  output logic                   cmd_valid,
  output logic [1:0]             cmd_dir,
  input  logic                   cmd_ready,
  input  logic                   move_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   timeout
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [2:0]       dir_q, dir_d;
  logic             upd_last_q, upd_last_d;
  cmd_state_t       state_q, state_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [1:0]       cmd_dir_q, cmd_dir_d;
  logic             overflow_q, overflow_d;
  logic             new_cmd, pop, expire;
  logic             fifo_full, fifo_empty;
  logic [1:0]       fifo_head;
  logic [CNT_W-1:0] fifo_cnt;

  dir_fifo #(.DEPTH(DEPTH), .WIDTH(2)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (new_cmd),
    .push_data (dir_q[DIR_MSB:0]),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  always_comb begin
    dir_d       = dir_in;
    new_cmd     = (dir_q[UPD_BIT] != upd_last_q);
    upd_last_d  = new_cmd ? dir_q[UPD_BIT] : upd_last_q;
    pop         = (state_q == ISSUE) && cmd_valid_q && cmd_ready;
    overflow_d  = overflow_q | (new_cmd & fifo_full & ~pop);
    state_d     = state_q;
    cmd_valid_d = 1'b0;
    cmd_dir_d   = cmd_dir_q;
    case (state_q)
      IDLE: begin
        // Latch the head on entry so cmd_dir stays stable for the whole offer.
        if (!fifo_empty) begin
          state_d     = ISSUE;
          cmd_valid_d = 1'b1;
          cmd_dir_d   = fifo_head;
        end
      end
      ISSUE: begin
        cmd_valid_d = 1'b1;
        if (pop) begin
          state_d     = BUSY;
          cmd_valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (move_done || expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q       <= '0;
      upd_last_q  <= 1'b0;
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_dir_q   <= 2'b00;
      overflow_q  <= 1'b0;
    end else begin
      dir_q       <= dir_d;
      upd_last_q  <= upd_last_d;
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_dir_q   <= cmd_dir_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef DIR_BUFFER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;

  // timer_q counts completed BUSY cycles; expiry lands on the last allowed one.
  always_comb begin
    timer_d   = (state_q == BUSY) ? timer_q + TMR_W'(1) : '0;
    expire    = (state_q == BUSY) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    timeout_d = timeout_q | (expire & ~move_done);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // Without the watchdog BUSY waits for move_done alone; expire is constant 0.
  assign expire  = (TIMEOUT_CYCLES < 0);
  assign timeout = 1'b0;
`endif

  assign cmd_valid  = cmd_valid_q;
  assign cmd_dir    = cmd_dir_q;
  assign busy       = (state_q == BUSY);
  assign fifo_count = fifo_cnt;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_direction_cmd_buffer.sv
// Self-checking bench for direction_cmd_buffer: queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_direction_cmd_buffer;
  localparam int DEPTH = 4;
  localparam int TMO   = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dir_in;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic       cmd_ready;
  logic       move_done;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  direction_cmd_buffer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .dir_in     (dir_in),
    .cmd_valid  (cmd_valid),
    .cmd_dir    (cmd_dir),
    .cmd_ready  (cmd_ready),
    .move_done  (move_done),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting, 1 = offering a command, 2 = move in progress.
  logic [2:0] m_dirq;
  logic       m_upd;
  logic [1:0] q[$];
  int         m_phase;
  logic [1:0] m_dir;
  logic       m_ovf, m_tmo;
  int         m_bc;
  bit         live = 0;

  always @(posedge clk) begin : model
    bit newc, hs;
    int ph;
    if (reset) begin
      m_dirq = '0; m_upd = 1'b0; q.delete(); m_phase = 0;
      m_dir = 2'b00; m_ovf = 1'b0; m_tmo = 1'b0; m_bc = 0;
      live = 1;
    end else if (live) begin
      newc = (m_dirq[2] != m_upd);
      hs   = (m_phase == 1) && cmd_ready;
      ph   = m_phase;
      case (m_phase)
        0: if (q.size() > 0) begin ph = 1; m_dir = q[0]; end
        1: if (hs) begin ph = 2; m_bc = 0; end
        default: begin
          if (move_done) ph = 0;
`ifdef DIR_BUFFER_TIMEOUT_EN
          else begin
            m_bc++;
            if (m_bc == TMO) begin ph = 0; m_tmo = 1'b1; end
          end
`endif
        end
      endcase
      if (hs) void'(q.pop_front());
      if (newc) begin
        m_upd = m_dirq[2];
        if (q.size() < DEPTH) q.push_back(m_dirq[1:0]);
        else m_ovf = 1'b1;
      end
      m_phase = ph;
      m_dirq  = dir_in;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("mdl_cmd_valid", cmd_valid, m_phase == 1);
      chk("mdl_busy", busy, m_phase == 2);
      chk("mdl_fifo_count", fifo_count, q.size());
      chk("mdl_overflow", overflow, m_ovf);
      chk("mdl_timeout", timeout, m_tmo);
      if (m_phase == 1) chk("mdl_cmd_dir", cmd_dir, m_dir);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [1:0] code);
    dir_in = {~dir_in[2], code};
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, cmd_valid, 1);
  endtask

  task automatic handshake();
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
  endtask

  task automatic finish_move();
    move_done = 1'b1;
    step(1);
    move_done = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; dir_in = 3'b000; cmd_ready = 1'b0; move_done = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  logic [1:0] fill_codes [5];
  logic [1:0] exp_seq [4];

  initial begin
    reset = 1'b1; dir_in = 3'b000; cmd_ready = 1'b0; move_done = 1'b0;
    step(3);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_dir", cmd_dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout, 0);

    // First command latency and no repeat while held.
    reset = 1'b0; dir_in = 3'b101;
    step(2);
    chk("lat_not_yet", cmd_valid, 0);
    chk("lat_count1", fifo_count, 1);
    step(1);
    chk("lat_valid", cmd_valid, 1);
    chk("lat_dir01", cmd_dir, 2'b01);
    step(5);
    chk("hold_count", fifo_count, 1);
    chk("hold_valid", cmd_valid, 1);
    handshake();
    chk("hs_busy", busy, 1);
    chk("hs_valid_low", cmd_valid, 0);
    chk("hs_count0", fifo_count, 0);
    finish_move();
    chk("done_idle", busy, 0);
    step(3);
    chk("no_second_cmd", cmd_valid, 0);

    // Command queued while busy is offered one cycle after returning to idle.
    send(2'b10);
    step(3);
    chk("c2_valid", cmd_valid, 1);
    chk("c2_dir", cmd_dir, 2'b10);
    handshake();
    send(2'b11);
    step(3);
    chk("c3_queued", fifo_count, 1);
    chk("c3_still_busy", busy, 1);
    move_done = 1'b1;
    step(1);
    move_done = 1'b0;
    chk("c3_idle_busy", busy, 0);
    chk("c3_idle_valid", cmd_valid, 0);
    step(1);
    chk("c3_valid", cmd_valid, 1);
    chk("c3_dir", cmd_dir, 2'b11);
    handshake();
    finish_move();

    // Overflow: five toggles into four slots, fifth code is dropped.
    fill_codes[0] = 2'b00; fill_codes[1] = 2'b01; fill_codes[2] = 2'b10;
    fill_codes[3] = 2'b11; fill_codes[4] = 2'b01;
    for (int i = 0; i < 5; i++) begin
      send(fill_codes[i]);
      step(1);
    end
    step(3);
    chk("ovf_count4", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    exp_seq[0] = 2'b00; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10; exp_seq[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_valid(8, "ovf_seq_valid");
      chk("ovf_seq_dir", cmd_dir, exp_seq[i]);
      handshake();
      finish_move();
    end
    step(4);
    chk("ovf_drained_valid", cmd_valid, 0);
    chk("ovf_drained_count", fifo_count, 0);
    chk("ovf_sticky", overflow, 1);

    // Full FIFO: pop and push on the same edge, no drop.
    pulse_reset();
    chk("clr_overflow", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      send(fill_codes[i]);
      step(1);
    end
    step(3);
    chk("full_count4", fifo_count, 4);
    send(2'b10);
    step(1);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    chk("pp_count4", fifo_count, 4);
    chk("pp_no_overflow", overflow, 0);
    chk("pp_busy", busy, 1);

    // Reset while busy with entries queued.
    pulse_reset();
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_dir", cmd_dir, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_timeout", timeout, 0);
    send(2'b10);
    step(2);
    chk("post_rst_not_yet", cmd_valid, 0);
    step(1);
    chk("post_rst_valid", cmd_valid, 1);
    chk("post_rst_dir", cmd_dir, 2'b10);
    handshake();
    finish_move();

`ifdef DIR_BUFFER_TIMEOUT_EN
    pulse_reset();
    send(2'b01);
    wait_valid(6, "tmo_valid");
    handshake();
    step(9);
    chk("tmo_busy_c10", busy, 1);
    chk("tmo_not_yet", timeout, 0);
    step(1);
    chk("tmo_idle", busy, 0);
    chk("tmo_flag", timeout, 1);
    pulse_reset();
    send(2'b01);
    wait_valid(6, "tmo2_valid");
    handshake();
    step(9);
    move_done = 1'b1;
    step(1);
    move_done = 1'b0;
    chk("tmo2_idle", busy, 0);
    chk("tmo2_no_flag", timeout, 0);
`endif

    // Randomised traffic, checked cycle by cycle against the model.
    pulse_reset();
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 2) == 0) send(2'($urandom_range(0, 3)));
      cmd_ready = ($urandom_range(0, 3) == 0);
      move_done = ($urandom_range(0, 4) == 0);
      step(1);
    end
    reset = 1'b0; cmd_ready = 1'b0; move_done = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/direction_cmd_buffer.md
# direction_cmd_buffer

Downstream consumer of the direction decoder's 3-bit output (bit 2 = update toggle, bits 1:0 = direction code). Detects each new command via a change of the update bit, queues it in a small FIFO, and issues commands one at a time to the motion controller, waiting for move completion before issuing the next. It decouples route-planner command timing from the robot's physical motion.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `TIMEOUT_CYCLES`, 50_000_000: BUSY-state watchdog limit; used only with `DIR_BUFFER_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `dir_in` in 3: decoder output; [2] update toggle, [1:0] direction code.
- `cmd_valid` out 1: command offered to the motion controller.
- `cmd_dir` out 2: direction code offered; meaningful only while `cmd_valid` is high.
- `cmd_ready` in 1: motion controller accepts the command.
- `move_done` in 1: one-cycle pulse; the accepted move has finished.
- `busy` out 1: a move is in progress (FSM state BUSY).
- `fifo_count` out $clog2(DEPTH)+1: entries queued.
- `overflow` out 1: sticky; a command was dropped because the FIFO was full.
- `timeout` out 1: sticky watchdog flag; tied to 0 without `DIR_BUFFER_TIMEOUT_EN`.

## Operation
- Input stage: register `dir_in` into `dir_q` every cycle. Track `upd_last`, the update bit of the last accepted command; it resets to 0.
- New command: `dir_q[2] != upd_last`. On a new command, push `dir_q[1:0]` and set `upd_last <= dir_q[2]`.
- FIFO: circular, with a read pointer, a write pointer and a count. Pointers wrap modulo DEPTH.
- Push when full with no pop in the same cycle: drop the entry, set `overflow`, and still update `upd_last`.
- Push and pop in the same cycle: both take effect and the count is unchanged. This also applies when the FIFO is full.
- FSM states IDLE, ISSUE, BUSY:
  - IDLE: if the FIFO is not empty, go to ISSUE.
  - ISSUE: `cmd_valid=1`, `cmd_dir` = FIFO head. On `cmd_valid && cmd_ready`, pop and go to BUSY.
  - BUSY: `busy=1`. On `move_done`, go to IDLE.
  - `move_done` outside BUSY is ignored.
- Once asserted in ISSUE, `cmd_valid` stays high and `cmd_dir` stays stable until the handshake completes.
- Direction codes are opaque to this block and are passed through unchanged.
- Reset mid-operation: the FIFO empties, any in-flight command is discarded, the FSM goes to IDLE and both sticky flags clear.

## Timing
- Reset values: `cmd_valid=0`, `cmd_dir=2'b00`, `busy=0`, `fifo_count=0`, `overflow=0`, `timeout=0`; FSM in IDLE; `upd_last=0`; pointers 0.
- `dir_in` toggles before edge N: `dir_q` captures it at edge N, the push happens at edge N+1, the FSM enters ISSUE at edge N+2, and `cmd_valid` is high in the cycle after edge N+2. With an idle FSM and an empty FIFO, latency is 3 cycles.
- Handshake completes at edge M: `busy` is high after M. `move_done` sampled at edge K puts the FSM in IDLE after K. If the FIFO is non-empty, `cmd_valid` is high after K+1.
- `cmd_valid` and `cmd_dir` are registered outputs.
- `overflow` is set in the cycle after the dropped push.

## Configuration
- `DIR_BUFFER_TIMEOUT_EN` defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without `move_done`, set `timeout` and go to IDLE; the move is abandoned.
  - `move_done` in the same cycle as expiry has priority: no timeout.
- `DIR_BUFFER_TIMEOUT_EN` undefined: no counter is synthesised, `timeout` is constant 0, and BUSY waits indefinitely.

## Structure
- Shared package `robot_pkg`:
  - `dir_code_t` enum: `DIR_STRAIGHT=2'b00`, `DIR_LEFT=2'b01`, `DIR_RIGHT=2'b10`, `DIR_UTURN=2'b11`.
  - `cmd_state_t` enum for IDLE/ISSUE/BUSY.
  - Bit-index constants `UPD_BIT=2`, `DIR_MSB=1`.
- One sub-module, `dir_fifo`: a parameterised synchronous FIFO with push, pop, full, empty, count and drop-on-full. The FSM and toggle detection stay in the top module.

## Test plan
- Reset, then `dir_in=3'b101` held: `cmd_valid` rises 3 cycles later with `cmd_dir=01`. Holding `dir_in` at 3'b101 produces no second command.
- Issue 3'b110, then 3'b011 while in BUSY: after `cmd_ready`, `busy=1`. After `move_done`, the second command is offered with `cmd_dir=11` one cycle after IDLE.
- Hold `cmd_ready=0` and send DEPTH+1=5 toggles: `fifo_count` reaches 4, `overflow=1`, and the 5th code is absent from the dispatched sequence.
- Full FIFO with `cmd_ready=1` and a toggle in the same cycle: `fifo_count` stays at 4 and `overflow` stays 0.
- Assert `reset` for one cycle while in BUSY with 2 entries queued: all outputs return to their reset values. A later toggle of bit 2 from 0 to 1 is detected as a new command.
- With `DIR_BUFFER_TIMEOUT_EN` defined and `TIMEOUT_CYCLES=10`, no `move_done`: `timeout=1` after 10 BUSY cycles and the FSM returns to IDLE. Repeat with `move_done` in cycle 10: `timeout` stays 0.
